// File: rtl/snake_engine_param.sv
// Snake game core: PS2 direction decode, timed grid stepping with a body buffer,
// wall/self/food hit detection and a registered per-pixel body query for the renderer.
module snake_engine_param #(
    parameter int COORD_W  = 11,
    parameter int STEP     = 10,
    parameter int X_MIN    = 210,
    parameter int X_MAX    = 710,
    parameter int Y_MIN    = 200,
    parameter int Y_MAX    = 460,
    parameter int START_X  = 470,
    parameter int START_Y  = 300,
    parameter int INIT_LEN = 3,
    parameter int MAX_LEN  = 16,
    parameter int WIN_LEN  = 10,
    parameter int TICK_DIV = 2500000,
    parameter int FOOD_TOL = 5
) (
    input  logic                             clk,
    input  logic                             reset_to_start,
    input  logic [7:0]                       ps2_data_out,
    input  logic [COORD_W-1:0]               food_x,
    input  logic [COORD_W-1:0]               food_y,
    input  logic [COORD_W-1:0]               query_x,
    input  logic [COORD_W-1:0]               query_y,
    output logic                             query_hit,
    output logic [COORD_W-1:0]               head_x,
    output logic [COORD_W-1:0]               head_y,
    output logic [$clog2(MAX_LEN+1)-1:0]     length,
    output logic                             food_eaten,
    output logic                             running,
    output logic                             you_win,
    output logic                             you_lose
);
    localparam int LEN_W  = $clog2(MAX_LEN + 1);
    localparam int TICK_W = $clog2(TICK_DIV + 1);

    localparam logic [COORD_W-1:0] STEP_C     = COORD_W'(STEP);
    localparam logic [COORD_W-1:0] X_MIN_C    = COORD_W'(X_MIN);
    localparam logic [COORD_W-1:0] X_MAX_C    = COORD_W'(X_MAX);
    localparam logic [COORD_W-1:0] Y_MIN_C    = COORD_W'(Y_MIN);
    localparam logic [COORD_W-1:0] Y_MAX_C    = COORD_W'(Y_MAX);
    localparam logic [COORD_W-1:0] FOOD_TOL_C = COORD_W'(FOOD_TOL);
    localparam logic [LEN_W-1:0]   MAX_LEN_C  = LEN_W'(MAX_LEN);
    localparam logic [LEN_W-1:0]   WIN_LEN_C  = LEN_W'(WIN_LEN);
    localparam logic [LEN_W-1:0]   INIT_LEN_C = LEN_W'(INIT_LEN);
    localparam logic [TICK_W-1:0]  TICK_LAST  = TICK_W'(TICK_DIV - 1);

    localparam logic [7:0] KEY_UP    = 8'h43;
    localparam logic [7:0] KEY_DOWN  = 8'h42;
    localparam logic [7:0] KEY_LEFT  = 8'h3B;
    localparam logic [7:0] KEY_RIGHT = 8'h4B;
    localparam logic [7:0] KEY_SPACE = 8'h29;

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_WIN, ST_LOSE} state_t;
    typedef enum logic [1:0] {DIR_UP, DIR_DOWN, DIR_LEFT, DIR_RIGHT} dir_t;

    state_t               state_r;
    dir_t                 dir_r;
    dir_t                 pending_r;
    logic [TICK_W-1:0]    tick_r;
    logic                 grow_r;
    logic                 moved_r;
    logic [LEN_W-1:0]     len_r;
    logic [COORD_W-1:0]   seg_x_r [MAX_LEN];
    logic [COORD_W-1:0]   seg_y_r [MAX_LEN];
    logic                 food_eaten_r;
    logic                 running_r;
    logic                 you_win_r;
    logic                 you_lose_r;
    logic                 query_hit_r;

    state_t               next_state_s;
    dir_t                 key_dir_s;
    logic                 key_valid_s;
    logic                 move_s;
    logic                 lose_s;
    logic                 win_s;
    logic                 wall_s;
    logic                 self_s;
    logic                 food_hit_s;
    logic                 query_match_s;
    logic [COORD_W-1:0]   nx_s;
    logic [COORD_W-1:0]   ny_s;
    logic [LEN_W-1:0]     self_limit_s;
    logic [LEN_W-1:0]     new_len_s;

    function automatic logic is_opposite(input dir_t a, input dir_t b);
        case (a)
            DIR_UP:    return b == DIR_DOWN;
            DIR_DOWN:  return b == DIR_UP;
            DIR_LEFT:  return b == DIR_RIGHT;
            DIR_RIGHT: return b == DIR_LEFT;
            default:   return 1'b0;
        endcase
    endfunction

    function automatic logic [COORD_W-1:0] abs_diff(input logic [COORD_W-1:0] a,
                                                    input logic [COORD_W-1:0] b);
        return (a >= b) ? (a - b) : (b - a);
    endfunction

    // Next-move geometry, hit detection, key decode and next FSM state.
    always_comb begin
        key_valid_s = 1'b1;
        key_dir_s   = DIR_RIGHT;
        case (ps2_data_out)
            KEY_UP:    key_dir_s = DIR_UP;
            KEY_DOWN:  key_dir_s = DIR_DOWN;
            KEY_LEFT:  key_dir_s = DIR_LEFT;
            KEY_RIGHT: key_dir_s = DIR_RIGHT;
            default:   key_valid_s = 1'b0;
        endcase

        nx_s = seg_x_r[0];
        ny_s = seg_y_r[0];
        case (pending_r)
            DIR_UP:    ny_s = seg_y_r[0] - STEP_C;
            DIR_DOWN:  ny_s = seg_y_r[0] + STEP_C;
            DIR_LEFT:  nx_s = seg_x_r[0] - STEP_C;
            DIR_RIGHT: nx_s = seg_x_r[0] + STEP_C;
            default:   nx_s = seg_x_r[0];
        endcase

        move_s = (state_r == ST_RUN) && (tick_r == TICK_LAST);
        wall_s = (nx_s <= X_MIN_C) || (nx_s >= X_MAX_C) ||
                 (ny_s <= Y_MIN_C) || (ny_s >= Y_MAX_C);

        // The tail vacates its cell on a non-growing move, so it cannot be hit.
        self_limit_s  = grow_r ? len_r : (len_r - LEN_W'(1));
        self_s        = 1'b0;
        query_match_s = 1'b0;
        for (int i = 0; i < MAX_LEN; i++) begin
            if ((LEN_W'(i) < self_limit_s) && (seg_x_r[i] == nx_s) && (seg_y_r[i] == ny_s)) begin
                self_s = 1'b1;
            end else begin
                self_s = self_s;
            end
            if ((LEN_W'(i) < len_r) && (seg_x_r[i] == query_x) && (seg_y_r[i] == query_y)) begin
                query_match_s = 1'b1;
            end else begin
                query_match_s = query_match_s;
            end
        end

        lose_s    = move_s && (wall_s || self_s);
        new_len_s = (grow_r && (len_r < MAX_LEN_C)) ? (len_r + LEN_W'(1)) : len_r;
        win_s     = move_s && !lose_s && (new_len_s == WIN_LEN_C);

        food_hit_s = moved_r && (state_r == ST_RUN) &&
                     (abs_diff(seg_x_r[0], food_x) <= FOOD_TOL_C) &&
                     (abs_diff(seg_y_r[0], food_y) <= FOOD_TOL_C);

        next_state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (ps2_data_out == KEY_SPACE) next_state_s = ST_RUN;
                else                           next_state_s = ST_IDLE;
            end
            ST_RUN: begin
                if (lose_s)     next_state_s = ST_LOSE;
                else if (win_s) next_state_s = ST_WIN;
                else            next_state_s = ST_RUN;
            end
            ST_WIN:  next_state_s = ST_WIN;
            ST_LOSE: next_state_s = ST_LOSE;
            default: next_state_s = ST_IDLE;
        endcase
    end

    // Game state, body buffer, direction latch, move timer and registered outputs.
    always_ff @(posedge clk) begin
        if (reset_to_start) begin
            state_r      <= ST_IDLE;
            dir_r        <= DIR_RIGHT;
            pending_r    <= DIR_RIGHT;
            tick_r       <= '0;
            grow_r       <= 1'b0;
            moved_r      <= 1'b0;
            len_r        <= INIT_LEN_C;
            food_eaten_r <= 1'b0;
            running_r    <= 1'b0;
            you_win_r    <= 1'b0;
            you_lose_r   <= 1'b0;
            query_hit_r  <= 1'b0;
            for (int i = 0; i < MAX_LEN; i++) begin
                seg_x_r[i] <= COORD_W'(START_X - i * STEP);
                seg_y_r[i] <= COORD_W'(START_Y);
            end
        end else begin
            state_r      <= next_state_s;
            running_r    <= (next_state_s == ST_RUN);
            you_win_r    <= (next_state_s == ST_WIN);
            you_lose_r   <= (next_state_s == ST_LOSE);
            query_hit_r  <= query_match_s;
            food_eaten_r <= food_hit_s;
            moved_r      <= move_s && !lose_s;

            if (((state_r == ST_IDLE) || (state_r == ST_RUN)) && key_valid_s &&
                !is_opposite(key_dir_s, dir_r)) begin
                pending_r <= key_dir_s;
            end

            if (state_r == ST_RUN) tick_r <= move_s ? '0 : (tick_r + TICK_W'(1));
            else                   tick_r <= '0;

            if (move_s) dir_r <= pending_r;

            if (move_s && !lose_s) begin
                for (int i = 1; i < MAX_LEN; i++) begin
                    seg_x_r[i] <= seg_x_r[i-1];
                    seg_y_r[i] <= seg_y_r[i-1];
                end
                seg_x_r[0] <= nx_s;
                seg_y_r[0] <= ny_s;
                len_r      <= new_len_s;
                grow_r     <= 1'b0;
            end
            // A food hit always arms growth for the following move.
            if (food_hit_s) grow_r <= 1'b1;
        end
    end

    assign head_x     = seg_x_r[0];
    assign head_y     = seg_y_r[0];
    assign length     = len_r;
    assign food_eaten = food_eaten_r;
    assign running    = running_r;
    assign you_win    = you_win_r;
    assign you_lose   = you_lose_r;
    assign query_hit  = query_hit_r;

endmodule

// File: tb/tb_snake_engine_param.sv
// Directed bench for snake_engine_param with a fast move tick (TICK_DIV=4).
module tb_snake_engine_param;
    localparam int CW = 11;
    localparam int LW = 5;

    localparam logic [7:0] K_I = 8'h43;
    localparam logic [7:0] K_K = 8'h42;
    localparam logic [7:0] K_J = 8'h3B;
    localparam logic [7:0] K_L = 8'h4B;
    localparam logic [7:0] K_SP = 8'h29;

    logic          clk = 1'b0;
    logic          reset_to_start;
    logic [7:0]    ps2_data_out;
    logic [CW-1:0] food_x, food_y, query_x, query_y;
    logic          query_hit;
    logic [CW-1:0] head_x, head_y;
    logic [LW-1:0] length;
    logic          food_eaten, running, you_win, you_lose;

    int tests = 0;
    int fails = 0;

    snake_engine_param #(.TICK_DIV(4)) dut (
        .clk(clk), .reset_to_start(reset_to_start), .ps2_data_out(ps2_data_out),
        .food_x(food_x), .food_y(food_y), .query_x(query_x), .query_y(query_y),
        .query_hit(query_hit), .head_x(head_x), .head_y(head_y), .length(length),
        .food_eaten(food_eaten), .running(running), .you_win(you_win), .you_lose(you_lose)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic clk_n(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_to_start = 1'b1;
        ps2_data_out   = 8'h00;
        clk_n(2);
        reset_to_start = 1'b0;
    endtask

    task automatic start_game();
        ps2_data_out = K_SP;
        clk_n(1);
        ps2_data_out = 8'h00;
    endtask

    task automatic press(input logic [7:0] code);
        ps2_data_out = code;
        clk_n(1);
        ps2_data_out = 8'h00;
    endtask

    initial begin
        reset_to_start = 1'b1;
        ps2_data_out   = 8'h00;
        food_x = 11'd100; food_y = 11'd100;
        query_x = 11'd0;  query_y = 11'd0;

        // Reset state and body query in IDLE
        do_reset();
        check("rst_head_x", 32'(head_x), 32'd470);
        check("rst_head_y", 32'(head_y), 32'd300);
        check("rst_length", 32'(length), 32'd3);
        check("rst_running", 32'(running), 32'd0);
        check("rst_win", 32'(you_win), 32'd0);
        check("rst_lose", 32'(you_lose), 32'd0);
        check("rst_food", 32'(food_eaten), 32'd0);
        check("rst_query", 32'(query_hit), 32'd0);
        query_x = 11'd470; query_y = 11'd300;
        clk_n(1);
        check("query_head", 32'(query_hit), 32'd1);
        query_x = 11'd450;
        clk_n(1);
        check("query_tail", 32'(query_hit), 32'd1);
        query_x = 11'd440;
        clk_n(1);
        check("query_past_tail", 32'(query_hit), 32'd0);
        query_x = 11'd0; query_y = 11'd0;

        // Start and straight moves at 4-clock spacing
        start_game();
        check("run_running", 32'(running), 32'd1);
        clk_n(3);
        check("pre_move1_x", 32'(head_x), 32'd470);
        clk_n(1);
        check("move1_x", 32'(head_x), 32'd480);
        clk_n(4);
        check("move2_x", 32'(head_x), 32'd490);

        // Reverse key ignored; I then J in one tick takes UP
        press(K_J);
        clk_n(3);
        check("rev_x", 32'(head_x), 32'd500);
        check("rev_y", 32'(head_y), 32'd300);
        press(K_I);
        press(K_J);
        clk_n(2);
        check("up_x", 32'(head_x), 32'd500);
        check("up_y", 32'(head_y), 32'd290);

        // Right wall: 700 is the last legal column
        do_reset();
        start_game();
        ps2_data_out = K_L;
        clk_n(92);
        check("wall_pre_x", 32'(head_x), 32'd700);
        check("wall_pre_run", 32'(running), 32'd1);
        clk_n(4);
        check("wall_lose", 32'(you_lose), 32'd1);
        check("wall_run", 32'(running), 32'd0);
        check("wall_x", 32'(head_x), 32'd700);
        check("wall_len", 32'(length), 32'd3);
        clk_n(8);
        check("wall_hold", 32'(you_lose), 32'd1);
        check("wall_hold_x", 32'(head_x), 32'd700);
        ps2_data_out = 8'h00;

        // Food within tolerance, then growth on the next move
        do_reset();
        food_x = 11'd482; food_y = 11'd298;
        start_game();
        clk_n(4);
        check("food_head", 32'(head_x), 32'd480);
        check("food_not_yet", 32'(food_eaten), 32'd0);
        clk_n(1);
        check("food_pulse", 32'(food_eaten), 32'd1);
        check("food_len3", 32'(length), 32'd3);
        clk_n(1);
        check("food_pulse_end", 32'(food_eaten), 32'd0);
        food_x = 11'd500; food_y = 11'd300;
        clk_n(2);
        check("grow_len4", 32'(length), 32'd4);
        check("grow_head", 32'(head_x), 32'd490);
        clk_n(5);
        check("food2_pulse", 32'(food_eaten), 32'd1);
        food_x = 11'd100; food_y = 11'd100;
        clk_n(3);
        check("grow_len5", 32'(length), 32'd5);
        check("grow5_head", 32'(head_x), 32'd510);

        // UP, LEFT, DOWN on length 5 runs into own body
        press(K_I);
        clk_n(3);
        check("loop_up_y", 32'(head_y), 32'd290);
        press(K_J);
        clk_n(3);
        check("loop_left_x", 32'(head_x), 32'd500);
        press(K_K);
        clk_n(3);
        check("self_lose", 32'(you_lose), 32'd1);
        check("self_run", 32'(running), 32'd0);
        check("self_head_x", 32'(head_x), 32'd500);
        check("self_head_y", 32'(head_y), 32'd290);

        // Feed 7 foods on consecutive moves; length 10 wins
        do_reset();
        start_game();
        for (int k = 0; k < 7; k++) begin
            clk_n(1);
            if (k > 0) check("win_feed_pulse", 32'(food_eaten), 32'd1);
            food_x = CW'(480 + 10 * k); food_y = 11'd300;
            clk_n(3);
        end
        check("win_len9", 32'(length), 32'd9);
        check("win_pre_run", 32'(running), 32'd1);
        clk_n(1);
        check("win_feed7", 32'(food_eaten), 32'd1);
        food_x = 11'd550;
        clk_n(3);
        check("win_len10", 32'(length), 32'd10);
        check("win_flag", 32'(you_win), 32'd1);
        check("win_run", 32'(running), 32'd0);
        clk_n(1);
        check("win_no_food", 32'(food_eaten), 32'd0);
        food_x = 11'd100; food_y = 11'd100;

        // Reset from WIN and from mid-RUN
        do_reset();
        check("unwin", 32'(you_win), 32'd0);
        check("unwin_len", 32'(length), 32'd3);
        start_game();
        clk_n(5);
        check("mid_head", 32'(head_x), 32'd480);
        reset_to_start = 1'b1;
        clk_n(1);
        reset_to_start = 1'b0;
        check("mid_rst_x", 32'(head_x), 32'd470);
        check("mid_rst_y", 32'(head_y), 32'd300);
        check("mid_rst_len", 32'(length), 32'd3);
        check("mid_rst_run", 32'(running), 32'd0);
        check("mid_rst_lose", 32'(you_lose), 32'd0);
        start_game();
        clk_n(3);
        check("restart_hold", 32'(head_x), 32'd470);
        clk_n(1);
        check("restart_move", 32'(head_x), 32'd480);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
